// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction memory read port, redirect input and decode handshake.
// The master side belongs to the fetch queue; the slave side belongs to memory/decode.

`ifndef WORDSIZE
`define WORDSIZE 32
`endif

interface fetch_queue_if;

   logic                 imem_en;
   logic [`WORDSIZE-1:0] imem_addr;
   logic [`WORDSIZE-1:0] imem_rdata;
   logic                 redir_valid;
   logic [`WORDSIZE-1:0] redir_pc;
   logic                 out_valid;
   logic                 out_ready;
   logic [`WORDSIZE-1:0] out_inst;
   logic [`WORDSIZE-1:0] out_pc;

   modport master (
      output imem_en,
      output imem_addr,
      input  imem_rdata,
      input  redir_valid,
      input  redir_pc,
      output out_valid,
      input  out_ready,
      output out_inst,
      output out_pc
   );

   modport slave (
      input  imem_en,
      input  imem_addr,
      output imem_rdata,
      output redir_valid,
      output redir_pc,
      input  out_valid,
      output out_ready,
      input  out_inst,
      input  out_pc
   );

endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential reads to a one-cycle-latency instruction
// memory, buffers the returned {pc, inst} pairs in a small FIFO and hands them to decode.
// A redirect reloads the fetch PC, flushes the FIFO and squashes the read in flight.

`ifndef WORDSIZE
`define WORDSIZE 32
`endif

module fetch_queue #(
   parameter int                   DEPTH    = 4,
   parameter logic [`WORDSIZE-1:0] RESET_PC = '0
) (
   input  logic          CLK,
   input  logic          reset,
   fetch_queue_if.master bus
);

   localparam int W  = `WORDSIZE;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [W-1:0]  PC_ONE    = W'(1);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW:0]   OCC_LIMIT = (CW + 1)'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fetch_queue: DEPTH must be a power of two and at least 2");
   end

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      BUBBLE
   } state_t;

   state_t          state_q,    state_d;
   logic [W-1:0]    fetchPc_q,  fetchPc_d;
   logic [W-1:0]    pendPc_q,   pendPc_d;
   logic            inflight_q, inflight_d;
   logic [CW-1:0]   count_q,    count_d;
   logic [PW-1:0]   rdPtr_q,    rdPtr_d;
   logic [PW-1:0]   wrPtr_q,    wrPtr_d;

   logic [W-1:0]    pcMem   [DEPTH];
   logic [W-1:0]    instMem [DEPTH];

   logic [CW:0]     occupancy;
   logic            outValid;
   logic            deq;
   logic            enq;
   logic            roomOk;
   logic            issue;

   // Handshake qualifiers: a redirect cancels both the dequeue and the returning response,
   // and an issue is allowed only if the queue can absorb its response next cycle.
   always_comb begin
      occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
      outValid  = (count_q != '0) && !reset;
      deq       = outValid && bus.out_ready && !bus.redir_valid;
      enq       = inflight_q && !bus.redir_valid;
      roomOk    = (occupancy < OCC_LIMIT) || ((occupancy == OCC_LIMIT) && deq);
      issue     = (state_q == RUN) && !bus.redir_valid && !reset && roomOk;
   end

   // Next-state logic for the fetch FSM, fetch PC, in-flight tracking and FIFO bookkeeping.
   always_comb begin
      state_d    = state_q;
      fetchPc_d  = fetchPc_q;
      pendPc_d   = pendPc_q;
      inflight_d = issue;
      count_d    = count_q;
      rdPtr_d    = rdPtr_q;
      wrPtr_d    = wrPtr_q;

      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     state_d = RUN;
         BUBBLE:  state_d = RUN;
         default: state_d = BOOT;
      endcase

      if (issue) begin
         fetchPc_d = fetchPc_q + PC_ONE;
         pendPc_d  = fetchPc_q;
      end

      if (enq) begin
         wrPtr_d = wrPtr_q + PTR_ONE;
      end
      if (deq) begin
         rdPtr_d = rdPtr_q + PTR_ONE;
      end

      case ({enq, deq})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      if (bus.redir_valid) begin
         fetchPc_d  = bus.redir_pc;
         count_d    = '0;
         rdPtr_d    = '0;
         wrPtr_d    = '0;
         inflight_d = 1'b0;
         state_d    = BUBBLE;
      end
   end

   // Control registers; reset wins over a redirect and forgets any read in flight.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q    <= BOOT;
         fetchPc_q  <= RESET_PC;
         pendPc_q   <= '0;
         inflight_q <= 1'b0;
         count_q    <= '0;
         rdPtr_q    <= '0;
         wrPtr_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetchPc_q  <= fetchPc_d;
         pendPc_q   <= pendPc_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         rdPtr_q    <= rdPtr_d;
         wrPtr_q    <= wrPtr_d;
      end
   end

   // FIFO storage: the returning word is written at the tail together with its fetch address.
   always_ff @(posedge CLK) begin
      if (enq && !reset) begin
         pcMem[wrPtr_q]   <= pendPc_q;
         instMem[wrPtr_q] <= bus.imem_rdata;
      end
   end

   // Memory read port and decode-side view of the FIFO head.
   always_comb begin
      bus.imem_en   = issue;
      bus.imem_addr = fetchPc_q;
      bus.out_valid = outValid;
      bus.out_inst  = instMem[rdPtr_q];
      bus.out_pc    = pcMem[rdPtr_q];
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed latency/stall/redirect/reset scenarios followed by
// a long randomized run, all checked against a transaction-level model of the fetch stream.

`ifndef WORDSIZE
`define WORDSIZE 32
`endif

module tb_fetch_queue;

   localparam int           W     = `WORDSIZE;
   localparam int           DEPTH = 4;
   localparam logic [W-1:0] RPC   = '0;

   logic CLK   = 1'b0;
   logic reset = 1'b1;

   fetch_queue_if bus ();

   fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RPC)
   ) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock.
   always #5 CLK = ~CLK;

   // Instruction memory: one-cycle read latency, word = address + 0x100, junk when idle.
   always @(posedge CLK) begin
      bus.imem_rdata <= bus.imem_en ? (bus.imem_addr + W'(32'h100)) : W'(32'hDEAD_BEEF);
   end

   int testsRun    = 0;
   int testsFailed = 0;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference model state: the fetch stream is sequential from the last reset/redirect
   // target, so issued and delivered addresses are just counters restarted at those events.
   bit           monEn = 1'b0;
   logic [W-1:0] expIssue;
   logic [W-1:0] expDeliver;
   int           mCount;
   int           mInflight;
   bit           mDeq;

   // Every cycle, compare the DUT against the stream model while inputs and outputs are stable.
   always @(negedge CLK) begin
      if (monEn) begin
         if (reset) begin
            checkOutput("rst_imem_en", W'(bus.imem_en), '0);
            checkOutput("rst_out_valid", W'(bus.out_valid), '0);
            expIssue   = RPC;
            expDeliver = RPC;
            mCount     = 0;
            mInflight  = 0;
         end else begin
            mDeq = bus.out_valid && bus.out_ready && !bus.redir_valid;
            checkOutput("out_valid", W'(bus.out_valid), W'(mCount > 0));
            if (bus.out_valid) begin
               checkOutput("out_pc", bus.out_pc, expDeliver);
               checkOutput("out_inst", bus.out_inst, expDeliver + W'(32'h100));
            end
            if (bus.redir_valid) begin
               checkOutput("redir_no_issue", W'(bus.imem_en), '0);
            end
            if (bus.imem_en) begin
               checkOutput("issue_addr", bus.imem_addr, expIssue);
               checkOutput("issue_room", W'(((mCount + mInflight) < DEPTH) || mDeq), W'(1));
               expIssue = expIssue + W'(1);
            end
            mCount    = mCount + mInflight - (mDeq ? 1 : 0);
            mInflight = bus.imem_en ? 1 : 0;
            if (mDeq) begin
               expDeliver = expDeliver + W'(1);
            end
            if (bus.redir_valid) begin
               mCount     = 0;
               mInflight  = 0;
               expIssue   = bus.redir_pc;
               expDeliver = bus.redir_pc;
            end
            checkOutput("count_bound", W'(mCount <= DEPTH), W'(1));
         end
      end
   end

   // Drive one cycle of inputs just after the rising edge, then wait to the falling edge.
   task automatic applyStimulus(input bit rst, input bit rv, input logic [W-1:0] rpc,
                                input bit rdy);
      @(posedge CLK);
      #1;
      reset           = rst;
      bus.redir_valid = rv;
      bus.redir_pc    = rpc;
      bus.out_ready   = rdy;
      @(negedge CLK);
   endtask

   // Two reset cycles, then the first cycle after deassertion (the BOOT cycle).
   task automatic doReset(input bit rdy);
      applyStimulus(1'b1, 1'b0, '0, rdy);
      applyStimulus(1'b1, 1'b0, '0, rdy);
      applyStimulus(1'b0, 1'b0, '0, rdy);
   endtask

   int            issues;
   logic [W-1:0]  rndPc;

   initial begin
      bus.redir_valid = 1'b0;
      bus.redir_pc    = '0;
      bus.out_ready   = 1'b0;

      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      monEn = 1'b1;

      // Streaming from reset: first issue in the second cycle, first delivery two cycles later.
      doReset(1'b1);
      checkOutput("boot_no_issue", W'(bus.imem_en), '0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("first_issue_en", W'(bus.imem_en), W'(1));
      checkOutput("first_issue_addr", bus.imem_addr, RPC);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("first_latency_valid", W'(bus.out_valid), '0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("first_out_valid", W'(bus.out_valid), W'(1));
      checkOutput("first_out_pc", bus.out_pc, RPC);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b0, '0, 1'b1);
         checkOutput("throughput_valid", W'(bus.out_valid), W'(1));
         checkOutput("throughput_issue", W'(bus.imem_en), W'(1));
      end

      // Decode stalled from reset: the queue fills with exactly DEPTH entries and stops.
      doReset(1'b0);
      issues = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b0, '0, 1'b0);
         if (bus.imem_en) issues++;
      end
      checkOutput("stall_issue_count", W'(issues), W'(DEPTH));
      checkOutput("stall_out_valid", W'(bus.out_valid), W'(1));
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("resume_issue_en", W'(bus.imem_en), W'(1));
      checkOutput("resume_issue_addr", bus.imem_addr, RPC + W'(DEPTH));
      checkOutput("resume_out_pc", bus.out_pc, RPC);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);

      // Redirect with three queued entries and a read in flight.
      doReset(1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, 1'b1, W'(32'h40), 1'b0);
      checkOutput("redir_issue_off", W'(bus.imem_en), '0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("redir_flush_valid", W'(bus.out_valid), '0);
      checkOutput("bubble_no_issue", W'(bus.imem_en), '0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("redir_issue_addr", bus.imem_addr, W'(32'h40));
      checkOutput("redir_issue_en", W'(bus.imem_en), W'(1));
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("redir_drop_valid", W'(bus.out_valid), '0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("redir_first_valid", W'(bus.out_valid), W'(1));
      checkOutput("redir_first_pc", bus.out_pc, W'(32'h40));

      // Fetch PC wraps from all-ones to zero.
      applyStimulus(1'b0, 1'b1, '1, 1'b1);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("wrap_bubble", W'(bus.imem_en), '0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("wrap_addr_max", bus.imem_addr, '1);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("wrap_addr_zero", bus.imem_addr, '0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("wrap_addr_one", bus.imem_addr, W'(1));
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);

      // Reset mid-stream with two queued entries and a read in flight.
      doReset(1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
      applyStimulus(1'b1, 1'b0, '0, 1'b1);
      checkOutput("midrst_valid", W'(bus.out_valid), '0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("postrst_valid", W'(bus.out_valid), '0);
      checkOutput("postrst_no_issue", W'(bus.imem_en), '0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("refetch_addr", bus.imem_addr, RPC);
      checkOutput("refetch_en", W'(bus.imem_en), W'(1));
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("refetch_gap", W'(bus.out_valid), '0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("refetch_pc", bus.out_pc, RPC);

      // Randomized traffic: random decode stalls, redirects (some near the wrap point), resets.
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            rndPc = '1 - W'($urandom_range(0, 3));
         end else begin
            rndPc = W'($urandom);
         end
         applyStimulus($urandom_range(0, 999) < 3,
                       $urandom_range(0, 19) == 0,
                       rndPc,
                       $urandom_range(0, 3) != 0);
      end

      monEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
